// File: rtl/fp16_mul_sched_pkg.sv
// rtl/fp16_mul_sched_pkg.sv - shared types and widths for the fp16 x fixed-point multiply scheduler
package fp16_mul_sched_pkg;

  localparam int FP16_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot grant, searching upward from ptr_i with wrap
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  logic found;
  int   idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp16_fxp8_mul_arbiter.sv
// rtl/fp16_fxp8_mul_arbiter.sv - shares one external fp16 x fixed-point multiplier among NUM_REQ requesters
module fp16_fxp8_mul_arbiter
  import fp16_mul_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int FXP_WIDTH   = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [FP16_WIDTH*NUM_REQ-1:0]   req_a,
  input  logic [FXP_WIDTH*NUM_REQ-1:0]    req_b,
  output logic [FP16_WIDTH-1:0]           mul_a,
  output logic [FXP_WIDTH-1:0]            mul_b,
  input  logic [FP16_WIDTH-1:0]           mul_result,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [FP16_WIDTH-1:0]           rsp_data,
  output logic                            busy,
  output logic                            drain_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int DEPTH = MUL_LATENCY + 1;
  localparam int CNT_W = $clog2(MUL_LATENCY + 3);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FP16_WIDTH-1:0]   mul_a_q;
  logic [FXP_WIDTH-1:0]    mul_b_q;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [FP16_WIDTH-1:0]   rsp_data_q;
  logic                    drain_done_q, drain_done_d;
  logic [DEPTH-1:0]        tag_vld_q;
  logic [IDX_W-1:0]        tag_idx_q [DEPTH];

  logic [NUM_REQ-1:0]      rr_grant;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    xfer;
  logic                    rsp_any;
  logic [FP16_WIDTH-1:0]   op_a;
  logic [FXP_WIDTH-1:0]    op_b;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (IDX_W)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant)
  );

  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    req_ready    = '0;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN: begin
        req_ready = rr_grant;
        if (!enable) state_d = ST_DRAIN;
      end
      // Re-enable while draining is ignored here; IDLE picks it up next cycle.
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d      = ST_IDLE;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) gnt_idx = IDX_W'(i);
    end
  end

  assign xfer    = |(req_valid & req_ready);
  assign rsp_any = |rsp_valid_q;
  assign op_a    = req_a[int'(gnt_idx)*FP16_WIDTH +: FP16_WIDTH];
  assign op_b    = req_b[int'(gnt_idx)*FXP_WIDTH +: FXP_WIDTH];

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      if (int'(gnt_idx) == NUM_REQ - 1) ptr_d = '0;
      else                              ptr_d = gnt_idx + IDX_W'(1);
    end
  end

  // Issue and retire in the same cycle cancel, so the count tops out at MUL_LATENCY+2.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer && !rsp_any)      cnt_d = cnt_q + CNT_W'(1);
    else if (!xfer && rsp_any) cnt_d = cnt_q - CNT_W'(1);
  end

  always_comb begin
    rsp_valid_d = '0;
    if (tag_vld_q[DEPTH-1]) rsp_valid_d = NUM_REQ'(1) << tag_idx_q[DEPTH-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      drain_done_q <= 1'b0;
      tag_vld_q    <= '0;
      for (int k = 0; k < DEPTH; k++) tag_idx_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      drain_done_q <= drain_done_d;
      if (xfer) begin
        mul_a_q <= op_a;
        mul_b_q <= op_b;
      end
      tag_vld_q    <= {tag_vld_q[DEPTH-2:0], xfer};
      tag_idx_q[0] <= gnt_idx;
      for (int k = 1; k < DEPTH; k++) tag_idx_q[k] <= tag_idx_q[k-1];
      rsp_valid_q  <= rsp_valid_d;
      if (tag_vld_q[DEPTH-1]) rsp_data_q <= mul_result;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign drain_done = drain_done_q;
  assign busy       = (state_q != ST_IDLE) || (cnt_q != '0);

endmodule

// File: doc/fp16_fxp8_mul_arbiter.md
FP16_FXP8_MUL_ARBITER -- requirements
Module: fp16_fxp8_mul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one fp16_fxp8_mul unit (2..8).
REQ-002 Parameter FXP_WIDTH, default 8: fixed-point operand width.
REQ-003 Parameter MUL_LATENCY, default 3: cycles from mul_a/mul_b to mul_result.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  1 = grant requests; 0 = stop granting and drain.
REQ-007 req_valid  in  NUM_REQ  per-requester operand valid.
REQ-008 req_ready  out  NUM_REQ  per-requester grant; at most one bit set.
REQ-009 req_a  in  16*NUM_REQ  fp16 operand, requester i at bits [16i+15:16i].
REQ-010 req_b  in  FXP_WIDTH*NUM_REQ  fixed-point operand, requester i packed likewise.
REQ-011 mul_a  out  16  registered fp16 operand to the multiplier.
REQ-012 mul_b  out  FXP_WIDTH  registered fixed-point operand to the multiplier.
REQ-013 mul_result  in  16  multiplier output.
REQ-014 rsp_valid  out  NUM_REQ  one-hot result strobe to the owning requester; no back-pressure.
REQ-015 rsp_data  out  16  registered result, shared by all requesters.
REQ-016 busy  out  1  high when state != IDLE or in-flight count != 0.
REQ-017 drain_done  out  1  one-cycle pulse on the DRAIN->IDLE transition.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN.
REQ-019 Transitions: IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE when in-flight count is 0.
REQ-020 If enable reasserts during DRAIN, DRAIN SHALL complete to IDLE; RUN is entered on the following cycle.
REQ-021 req_ready SHALL be 0 in IDLE and DRAIN.
REQ-022 In RUN, req_ready SHALL be a combinational round-robin one-hot over req_valid, searching from the priority pointer upward with wrap.
REQ-023 A transfer occurs when req_valid[i] and req_ready[i] are both 1; at most one transfer per cycle.
REQ-024 On a transfer from requester g, the pointer SHALL become (g+1) mod NUM_REQ; otherwise it holds.
REQ-025 A transfer in cycle T SHALL load mul_a/mul_b with that requester's operands, visible in cycle T+1.
REQ-026 mul_a/mul_b SHALL hold their last value when no transfer occurs.
REQ-027 A tag pipeline (valid bit plus requester index, depth 1+MUL_LATENCY) SHALL track each issue.
REQ-028 For a transfer in cycle T: rsp_valid[g]=1 and rsp_data=mul_result sampled at T+1+MUL_LATENCY, both visible in cycle T+2+MUL_LATENCY (total latency MUL_LATENCY+2).
REQ-029 rsp_valid SHALL be all-zero in cycles carrying no tagged result; rsp_data holds otherwise.
REQ-030 The in-flight counter SHALL increment on transfer and decrement on rsp_valid; if both occur in one cycle, it holds.
REQ-031 The counter SHALL be sized for a maximum of MUL_LATENCY+2 and SHALL never wrap.
REQ-032 Back-to-back transfers from different requesters SHALL produce back-to-back responses in issue order.

Reset
REQ-033 On reset: state=IDLE, pointer=0, counter=0, tag pipe cleared, and mul_a, mul_b, rsp_data, rsp_valid, drain_done all 0.
REQ-034 Reset mid-operation SHALL discard all in-flight operations; no rsp_valid SHALL follow for them.

Structure
REQ-035 Package fp16_mul_sched_pkg SHALL hold the state enum and FP16_WIDTH=16.
REQ-036 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant).
REQ-037 The multiplier SHALL be instantiated outside this block.

Verification
REQ-038 Bench SHALL model the multiplier as a MUL_LATENCY-stage delay of the golden product (MUL_LATENCY=3, NUM_REQ=4).
REQ-039 Single request: RUN; req0 a=0x3C00, b=0x02 transferred in cycle 5 -> rsp_valid=4'b0001 in cycle 10, rsp_data=0x4000.
REQ-040 Fairness: all four req_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3, with eight consecutive one-hot responses in the same order.
REQ-041 Drain: enable drops one cycle after the third transfer -> no further grants, busy stays high until the last response, drain_done pulses once, state returns to IDLE.
REQ-042 Simultaneous issue/retire: steady one transfer per cycle -> counter stays constant at 5.
REQ-043 Mid-flight reset: reset asserted 2 cycles after a transfer -> rsp_valid stays 0 for the next 10 cycles, and all outputs equal their REQ-033 values.
